// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - shared constants, types and helpers for the NES CPU bus master
package nes_bus_pkg;

    localparam logic [15:0] PRG_ROM_BASE = 16'h8000;
    localparam logic [15:0] WRAM_BASE    = 16'h6000;

    localparam logic [15:0] MAP_REG_8000 = 16'h8000;
    localparam logic [15:0] MAP_REG_8001 = 16'h8001;
    localparam logic [15:0] MAP_REG_A000 = 16'hA000;
    localparam logic [15:0] MAP_REG_A001 = 16'hA001;
    localparam logic [15:0] MAP_REG_C000 = 16'hC000;
    localparam logic [15:0] MAP_REG_C001 = 16'hC001;
    localparam logic [15:0] MAP_REG_E000 = 16'hE000;
    localparam logic [15:0] MAP_REG_E001 = 16'hE001;

    localparam int unsigned DEF_M2_LOW  = 3;
    localparam int unsigned DEF_M2_HIGH = 5;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2
    } bus_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wdata;
    } bus_cycle_t;

    // /ROMSEL is the NAND of A15 and M2 on the real console.
    function automatic logic romsel_of(input logic a15, input logic m2);
        return !(a15 && m2);
    endfunction

endpackage

// File: rtl/nes_cpu_bus_master_if.sv
// rtl/nes_cpu_bus_master_if.sv - request/response stream and cartridge CPU bus signals
interface nes_cpu_bus_master_if;

    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_rw;
    logic [7:0]  req_wdata;

    logic        rsp_valid;
    logic        rsp_write;
    logic [7:0]  rsp_rdata;

    logic        m2;
    logic        romsel;
    logic        cpu_rw_out;
    logic [14:0] cpu_addr_out;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_oe;
    logic [7:0]  cpu_data_in;

    logic        irq_n;
    logic        irq_active;

    modport master (
        input  req_valid, req_addr, req_rw, req_wdata, cpu_data_in, irq_n,
        output req_ready, rsp_valid, rsp_write, rsp_rdata,
        output m2, romsel, cpu_rw_out, cpu_addr_out, cpu_data_out, cpu_data_oe,
        output irq_active
    );

    modport slave (
        output req_valid, req_addr, req_rw, req_wdata, cpu_data_in, irq_n,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata,
        input  m2, romsel, cpu_rw_out, cpu_addr_out, cpu_data_out, cpu_data_oe,
        input  irq_active
    );

endinterface

// File: rtl/nes_cpu_bus_master_sync_2ff.sv
// rtl/nes_cpu_bus_master_sync_2ff.sv - two-flop synchronizer for the cartridge IRQ line
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/nes_cpu_bus_master.sv
// rtl/nes_cpu_bus_master.sv - turns a request stream into cycle-accurate NES CPU bus cycles
module nes_cpu_bus_master
    import nes_bus_pkg::*;
#(
    parameter int unsigned M2_LOW    = DEF_M2_LOW,
    parameter int unsigned M2_HIGH   = DEF_M2_HIGH,
    parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
    input logic                  clk,
    input logic                  rst_n,
    nes_cpu_bus_master_if.master bus
);

    localparam int unsigned P    = M2_LOW + M2_HIGH;
    localparam int unsigned PH_W = $clog2(P);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(P - 1);
    localparam logic [PH_W-1:0] PH_M2   = PH_W'(M2_LOW);
    localparam bus_cycle_t IDLE_CYCLE = '{addr: IDLE_ADDR, rw: 1'b1, wdata: 8'h00};

    generate
        if (M2_LOW < 1 || M2_HIGH < 2) begin : g_param_check
            $error("nes_cpu_bus_master: M2_LOW must be >= 1 and M2_HIGH must be >= 2");
        end
    endgenerate

    bus_state_t      state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    bus_cycle_t      cyc_q, cyc_d;
    logic            m2_q, m2_d;
    logic            romsel_q, romsel_d;
    logic            oe_q, oe_d;
    logic            ready_q, ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_write_q, rsp_write_d;
    logic [7:0]      rsp_rdata_q, rsp_rdata_d;
    logic            period_end;
    logic            accept;
    logic            irq_sync;

    always_comb begin
        period_end  = (ph_q == PH_LAST);
        accept      = period_end && ready_q && bus.req_valid;
        ph_d        = period_end ? '0 : ph_q + PH_W'(1);
        state_d     = state_q;
        cyc_d       = cyc_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_RESET: state_d = ST_IDLE;
            ST_IDLE,
            ST_BUSY: begin
                if (period_end) begin
                    state_d = accept ? ST_BUSY : ST_IDLE;
                end
            end
            default: state_d = ST_RESET;
        endcase

        // The period boundary both retires the running cycle and loads the next one;
        // read data is captured here because M2 is still high on this edge.
        if (period_end) begin
            if (state_q == ST_BUSY) begin
                rsp_valid_d = 1'b1;
                rsp_write_d = !cyc_q.rw;
                rsp_rdata_d = cyc_q.rw ? bus.cpu_data_in : 8'h00;
            end
            if (accept) begin
                cyc_d = '{addr: bus.req_addr, rw: bus.req_rw, wdata: bus.req_wdata};
            end else begin
                cyc_d = IDLE_CYCLE;
            end
        end

        // Outputs are registered, so they are computed from the phase of the coming tick.
        m2_d     = (ph_d >= PH_M2);
        romsel_d = romsel_of(cyc_d.addr[15], m2_d);
        oe_d     = !cyc_d.rw && m2_d;
        ready_d  = (ph_d == PH_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            ph_q        <= '0;
            cyc_q       <= IDLE_CYCLE;
            m2_q        <= 1'b0;
            romsel_q    <= 1'b1;
            oe_q        <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            cyc_q       <= cyc_d;
            m2_q        <= m2_d;
            romsel_q    <= romsel_d;
            oe_q        <= oe_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.irq_n),
        .q     (irq_sync)
    );

    assign bus.req_ready    = ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_write    = rsp_write_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.m2           = m2_q;
    assign bus.romsel       = romsel_q;
    assign bus.cpu_rw_out   = cyc_q.rw;
    assign bus.cpu_addr_out = cyc_q.addr[14:0];
    assign bus.cpu_data_out = cyc_q.wdata;
    assign bus.cpu_data_oe  = oe_q;
    assign bus.irq_active   = ~irq_sync;

endmodule

// File: tb/tb_nes_cpu_bus_master.sv
// tb/tb_nes_cpu_bus_master.sv - self-checking bench for nes_cpu_bus_master
module tb_nes_cpu_bus_master;
    import nes_bus_pkg::*;

    localparam int P    = 8;
    localparam int ML   = 3;
    localparam int MAXP = 1024;

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wdata;
        logic [7:0]  din;
        int          exp_romsel_low;
        int          exp_oe;
        logic [14:0] exp_addr;
        logic        exp_write;
        logic [7:0]  exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   tk = 0;

    // Reference model: bus cycle contents indexed by absolute period number since reset release.
    logic        pb_busy  [MAXP];
    logic [15:0] pb_addr  [MAXP];
    logic        pb_rw    [MAXP];
    logic [7:0]  pb_wdata [MAXP];
    logic [7:0]  pb_din   [MAXP];
    logic        exp_rsp_write;
    logic [7:0]  exp_rsp_rdata;
    logic        prev_romsel;
    int          fall_q[$];

    nes_cpu_bus_master_if bus ();

    nes_cpu_bus_master #(
        .M2_LOW    (3),
        .M2_HIGH   (5),
        .IDLE_ADDR (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tk);
        end
    endtask

    task automatic model_reset();
        tk = 0;
        foreach (pb_busy[i]) pb_busy[i] = 1'b0;
        exp_rsp_write = 1'b0;
        exp_rsp_rdata = 8'h00;
        prev_romsel   = 1'b1;
    endtask

    task automatic check_tick();
        int ph, n;
        logic busy, rw, m2e, rv;
        logic [15:0] a;
        logic [7:0] wd;
        ph   = tk % P;
        n    = tk / P;
        busy = (n < MAXP) && pb_busy[n];
        a    = busy ? pb_addr[n]  : 16'h0000;
        rw   = busy ? pb_rw[n]    : 1'b1;
        wd   = busy ? pb_wdata[n] : 8'h00;
        m2e  = (ph >= ML);
        rv   = (ph == 0) && (n > 0) && (n - 1 < MAXP) && pb_busy[n-1];
        if (rv) begin
            exp_rsp_write = !pb_rw[n-1];
            exp_rsp_rdata = pb_rw[n-1] ? pb_din[n-1] : 8'h00;
        end
        chk("m2", bus.m2, m2e);
        chk("romsel", bus.romsel, !(a[15] && m2e));
        chk("cpu_rw_out", bus.cpu_rw_out, rw);
        chk("cpu_addr_out", bus.cpu_addr_out, a[14:0]);
        chk("cpu_data_oe", bus.cpu_data_oe, !rw && m2e);
        chk("cpu_data_out", bus.cpu_data_out, wd);
        chk("req_ready", bus.req_ready, ph == P - 1);
        chk("rsp_valid", bus.rsp_valid, rv);
        chk("rsp_write", bus.rsp_write, exp_rsp_write);
        chk("rsp_rdata", bus.rsp_rdata, exp_rsp_rdata);
    endtask

    task automatic tick(input logic v, input logic [15:0] a, input logic rw,
                        input logic [7:0] wd, input logic [7:0] din, output logic acc);
        int ph, n;
        ph = tk % P;
        n  = tk / P;
        bus.req_valid   = v;
        bus.req_addr    = a;
        bus.req_rw      = rw;
        bus.req_wdata   = wd;
        bus.cpu_data_in = din;
        acc = v && (ph == P - 1);
        if (ph == P - 1 && n + 1 < MAXP) begin
            pb_din[n] = din;
            if (acc) begin
                pb_busy[n+1]  = 1'b1;
                pb_addr[n+1]  = a;
                pb_rw[n+1]    = rw;
                pb_wdata[n+1] = wd;
            end
        end
        @(posedge clk);
        tk++;
        @(negedge clk);
        check_tick();
        if (prev_romsel && !bus.romsel) fall_q.push_back(tk);
        prev_romsel = bus.romsel;
    endtask

    task automatic idle_tick();
        logic acc;
        tick(1'b0, 16'(($urandom)), 1'b0, 8'($urandom), 8'($urandom), acc);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " m2"}, bus.m2, 1'b0);
        chk({tag, " romsel"}, bus.romsel, 1'b1);
        chk({tag, " cpu_rw_out"}, bus.cpu_rw_out, 1'b1);
        chk({tag, " cpu_addr_out"}, bus.cpu_addr_out, 15'h0000);
        chk({tag, " cpu_data_out"}, bus.cpu_data_out, 8'h00);
        chk({tag, " cpu_data_oe"}, bus.cpu_data_oe, 1'b0);
        chk({tag, " req_ready"}, bus.req_ready, 1'b0);
        chk({tag, " rsp_valid"}, bus.rsp_valid, 1'b0);
        chk({tag, " rsp_write"}, bus.rsp_write, 1'b0);
        chk({tag, " rsp_rdata"}, bus.rsp_rdata, 8'h00);
        chk({tag, " irq_active"}, bus.irq_active, 1'b0);
    endtask

    task automatic do_txn(input vec_t v);
        logic acc, got;
        int t_acc, rs_low, oe_n, lat;
        logic [7:0] oe_dat;
        logic [14:0] addr_seen;
        acc = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 2 * P && !acc; i++) tick(1'b1, v.addr, v.rw, v.wdata, v.din, acc);
        chk("txn accepted", acc, 1'b1);
        t_acc     = tk;
        rs_low    = 0;
        oe_n      = 0;
        oe_dat    = 8'h00;
        addr_seen = bus.cpu_addr_out;
        for (int i = 1; i < P; i++) begin
            tick(1'b0, v.addr, v.rw, v.wdata, v.din, acc);
            if (!bus.romsel) rs_low++;
            if (bus.cpu_data_oe) begin
                oe_n++;
                oe_dat = bus.cpu_data_out;
            end
        end
        for (int i = 0; i < 2 * P && !got; i++) begin
            tick(1'b0, v.addr, v.rw, v.wdata, v.din, acc);
            if (bus.rsp_valid) begin
                got = 1'b1;
                lat = tk - t_acc + 1;
            end
        end
        chk("txn romsel low ticks", rs_low, v.exp_romsel_low);
        chk("txn oe ticks", oe_n, v.exp_oe);
        chk("txn oe data", oe_dat, (v.exp_oe > 0) ? v.wdata : 8'h00);
        chk("txn cpu_addr_out", addr_seen, v.exp_addr);
        chk("txn rsp seen", got, 1'b1);
        chk("txn latency", lat, P + 1);
        chk("txn rsp_write", bus.rsp_write, v.exp_write);
        chk("txn rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        logic [15:0] bb_addr[3];
        logic [7:0]  bb_data[3];
        int          acc_t[$];
        logic        acc, prev_m2;
        int          idx, m2_hi, m2_rise, oe_n, rv_n, rdy_n, addr_nz, rw0_n, rs_low;

        vecs[0] = '{PRG_ROM_BASE, 1'b0, 8'h06, 8'h00, 5, 5, 15'h0000, 1'b1, 8'h00};
        vecs[1] = '{WRAM_BASE,    1'b1, 8'h00, 8'hA5, 0, 0, 15'h6000, 1'b0, 8'hA5};
        vecs[2] = '{MAP_REG_C001, 1'b1, 8'h77, 8'h5A, 5, 0, 15'h4001, 1'b0, 8'h5A};
        vecs[3] = '{WRAM_BASE,    1'b0, 8'h3C, 8'hFF, 0, 5, 15'h6000, 1'b1, 8'h00};
        vecs[4] = '{MAP_REG_E001, 1'b0, 8'hFF, 8'h12, 5, 5, 15'h6001, 1'b1, 8'h00};
        vecs[5] = '{MAP_REG_8001, 1'b1, 8'h00, 8'h00, 5, 0, 15'h0001, 1'b0, 8'h00};
        bb_addr = '{MAP_REG_8000, MAP_REG_8001, MAP_REG_A000};
        bb_data = '{8'h01, 8'h02, 8'h03};

        rst_n           = 1'b0;
        bus.irq_n       = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_addr    = 16'h0000;
        bus.req_rw      = 1'b1;
        bus.req_wdata   = 8'h00;
        bus.cpu_data_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Back-to-back writes with req_valid held high.
        fall_q.delete();
        idx = 0;
        for (int i = 0; i < 6 * P && idx < 3; i++) begin
            tick(1'b1, bb_addr[idx], 1'b0, bb_data[idx], 8'h00, acc);
            if (acc) begin
                acc_t.push_back(tk);
                idx++;
            end
        end
        for (int i = 0; i < 3 * P; i++) idle_tick();
        chk("b2b accepted count", idx, 3);
        chk("b2b romsel pulses", fall_q.size(), 3);
        if (acc_t.size() == 3) begin
            chk("b2b accept gap 1", acc_t[1] - acc_t[0], P);
            chk("b2b accept gap 2", acc_t[2] - acc_t[1], P);
        end
        if (fall_q.size() == 3) begin
            chk("b2b romsel gap 1", fall_q[1] - fall_q[0], P);
            chk("b2b romsel gap 2", fall_q[2] - fall_q[1], P);
        end

        // Forty idle clocks starting from tick 0.
        for (int i = 0; i < P && (tk % P) != 0; i++) idle_tick();
        prev_m2 = bus.m2;
        {m2_hi, m2_rise, oe_n, rv_n, rdy_n, addr_nz, rw0_n} = '0;
        for (int i = 0; i < 40; i++) begin
            idle_tick();
            if (bus.m2) m2_hi++;
            if (bus.m2 && !prev_m2) m2_rise++;
            prev_m2 = bus.m2;
            if (bus.cpu_data_oe) oe_n++;
            if (bus.rsp_valid) rv_n++;
            if (bus.req_ready) rdy_n++;
            if (bus.cpu_addr_out != 15'h0000) addr_nz++;
            if (!bus.cpu_rw_out) rw0_n++;
        end
        chk("idle m2 high ticks", m2_hi, 25);
        chk("idle m2 rises", m2_rise, 5);
        chk("idle oe ticks", oe_n, 0);
        chk("idle rsp_valid ticks", rv_n, 0);
        chk("idle req_ready ticks", rdy_n, 5);
        chk("idle addr nonzero", addr_nz, 0);
        chk("idle write ticks", rw0_n, 0);

        // IRQ synchronizer: two-clock delay on both edges.
        bus.irq_n = 1'b0;
        idle_tick();
        chk("irq fall +1", bus.irq_active, 1'b0);
        idle_tick();
        chk("irq fall +2", bus.irq_active, 1'b1);
        bus.irq_n = 1'b1;
        idle_tick();
        chk("irq rise +1", bus.irq_active, 1'b1);
        idle_tick();
        chk("irq rise +2", bus.irq_active, 1'b0);

        // Randomized traffic against the period model.
        for (int i = 0; i < 300 * P; i++) begin
            tick(($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), acc);
        end
        for (int i = 0; i < 2 * P; i++) idle_tick();

        // Reset in the middle of a write to E001.
        acc = 1'b0;
        for (int i = 0; i < 2 * P && !acc; i++) tick(1'b1, MAP_REG_E001, 1'b0, 8'h9C, 8'h00, acc);
        chk("e001 accepted", acc, 1'b1);
        for (int i = 0; i < 4; i++) idle_tick();
        chk("e001 phase before reset", tk % P, 4);
        chk("e001 romsel low before reset", bus.romsel, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("midreset");
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("midreset hold rsp_valid", bus.rsp_valid, 1'b0);
        end
        rst_n = 1'b1;
        model_reset();
        {rs_low, oe_n, rv_n} = '0;
        for (int i = 0; i < 2 * P; i++) begin
            idle_tick();
            if (!bus.romsel) rs_low++;
            if (bus.cpu_data_oe) oe_n++;
            if (bus.rsp_valid) rv_n++;
        end
        chk("post-reset romsel low", rs_low, 0);
        chk("post-reset oe", oe_n, 0);
        chk("post-reset rsp_valid", rv_n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
